snake_ctrl: RTL and testbench
=============================

// Module: snake_ctrl
// PURPOSE
//  Game-rule controller that closes the loop around snake_pos: consumes the five segment
//  coordinates it produces and drives its dir/grow inputs. Filters player direction
//  requests, detects food capture, wall hits and self-collision once per pacemaker step,
//  places new food with an LFSR, and keeps score. Sits between input debounce and snake_pos/VGA.
// PARAMETERS
//  GRID_W    40       playfield width in cells (<=64); legal x = 0..GRID_W-1
//  GRID_H    30       playfield height in cells (<=32); legal y = 0..GRID_H-1
//  FOOD_X0   20       food x after reset
//  FOOD_Y0   15       food y after reset
//  LFSR_SEED 16'hACE1 LFSR reset value; must be nonzero
//  PLACE_MAX 64       max food placement attempts before keeping old food
// PORTS
//  clk          in  1  system clock
//  rst_n        in  1  async active-low reset
//  start        in  1  level; leaves IDLE/OVER
//  tick         in  1  1-cycle pulse from pacemaker; snake_pos steps on it
//  dir_req      in  2  requested direction: 0 up, 1 down, 2 left, 3 right
//  dir_valid    in  1  dir_req qualifier, 1 cycle
//  snake_x0..x4 in  9  segment x, 0 = head (each a separate port)
//  snake_y0..y4 in  9  segment y, 0 = head
//  dir          out 2  committed direction to snake_pos
//  grow         out 1  1-cycle pulse: lengthen snake on next step
//  food_x       out 9  food x
//  food_y       out 9  food y
//  score        out 8  foods eaten, saturating
//  game_over    out 1  level, high in OVER
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, dir=3, grow=0, food=(FOOD_X0,FOOD_Y0), score=0,
//   game_over=0, pend_dir=3, tick_pend=0, lfsr=LFSR_SEED, tries=0.
//  LFSR: 16-bit Fibonacci, x^16+x^14+x^13+x^11+1, shifts every clk in every state.
//  Dir filter: on dir_valid, pend_dir<=dir_req unless reversal of dir (dir_req[1]==dir[1] &&
//   dir_req[0]!=dir[0]) -> ignored. Last accepted request before tick wins. dir<=pend_dir
//   only in RUN on tick (so dir changes at most once per step). Check is against dir, not pend_dir.
//  FSM:
//   IDLE : start=1 -> RUN (score=0, game_over=0, food=(FOOD_X0,FOOD_Y0)). Ticks ignored.
//   RUN  : tick or tick_pend -> CHECK; clear tick_pend; commit dir.
//   CHECK: 1 cycle, evaluated the clk after tick (positions settled). Priority:
//          1 wall: head x>=GRID_W or y>=GRID_H (9-bit, 511 from underflow is caught) -> OVER
//          2 self: head == seg k, k=1..4 (x and y equal) -> OVER
//          3 food: head == food -> grow=1 for exactly this+1 cycle, score+1 (sat 255) -> PLACE
//          4 else -> RUN
//   PLACE: each clk candidate cx={3'b0,lfsr[5:0]}, cy={4'b0,lfsr[10:6]}; accept if cx<GRID_W,
//          cy<GRID_H and not on segments 0..4 -> food<=(cx,cy), RUN. Reject -> tries+1; after
//          PLACE_MAX rejects keep old food -> RUN. tries cleared on entry.
//   OVER : game_over=1; ticks ignored; start=1 -> RUN as from IDLE, dir=pend_dir=3.
//  tick arriving in CHECK or PLACE sets tick_pend (one deep; a second is dropped).
//  grow: registered, high one cycle (cycle after CHECK), never two consecutive cycles.
//  Simultaneous dir_valid and tick in RUN: tick commits old pend_dir; new request pends.
//  Latency: tick -> CHECK result (grow/game_over) = 2 clk.
// TESTING
//  1 reset, start, ticks with head moving right from (5,5): dir stays 3, grow never, score 0.
//  2 head=(20,15)=food on tick: grow high exactly 1 clk 2 clk after tick, score=1, new food
//    in range and off snake within PLACE_MAX+1 clk.
//  3 dir=3, dir_valid with dir_req=2 -> ignored; dir_req=0 then 1 before tick -> dir=1 after tick.
//  4 head x=40 (or 511) on tick -> game_over=1 two clk later; further ticks no change; start -> RUN, score 0.
//  5 head equals seg 3 -> OVER; head equals both food and seg 2 -> OVER, no grow, score unchanged.
//  6 assert rst_n low during PLACE -> all outputs at reset values immediately, state IDLE.

Source files
------------

// File: rtl/snake_ctrl.sv
// Game-rule controller for snake_pos: filters direction requests, checks wall/self/food
// once per pacemaker step, places new food from an LFSR and keeps a saturating score.
module snake_ctrl #(
    parameter int          GRID_W    = 40,
    parameter int          GRID_H    = 30,
    parameter int          FOOD_X0   = 20,
    parameter int          FOOD_Y0   = 15,
    parameter logic [15:0] LFSR_SEED = 16'hACE1,
    parameter int          PLACE_MAX = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       tick,
    input  logic [1:0] dir_req,
    input  logic       dir_valid,
    input  logic [8:0] snake_x0,
    input  logic [8:0] snake_x1,
    input  logic [8:0] snake_x2,
    input  logic [8:0] snake_x3,
    input  logic [8:0] snake_x4,
    input  logic [8:0] snake_y0,
    input  logic [8:0] snake_y1,
    input  logic [8:0] snake_y2,
    input  logic [8:0] snake_y3,
    input  logic [8:0] snake_y4,
    output logic [1:0] dir,
    output logic       grow,
    output logic [8:0] food_x,
    output logic [8:0] food_y,
    output logic [7:0] score,
    output logic       game_over
);

    localparam int         TRY_W   = $clog2(PLACE_MAX + 1);
    localparam logic [8:0] GW      = 9'(GRID_W);
    localparam logic [8:0] GH      = 9'(GRID_H);
    localparam logic [8:0] FX0     = 9'(FOOD_X0);
    localparam logic [8:0] FY0     = 9'(FOOD_Y0);
    localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(PLACE_MAX - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_CHECK,
        S_PLACE,
        S_OVER
    } state_t;

    state_t            state;
    logic [1:0]        pend_dir;
    logic              tick_pend;
    logic [15:0]       lfsr;
    logic [TRY_W-1:0]  tries;

    logic              lfsr_fb;
    logic              reversal;
    logic              wall_hit;
    logic              self_hit;
    logic              food_hit;
    logic [8:0]        cand_x;
    logic [8:0]        cand_y;
    logic              cand_on_snake;
    logic              cand_ok;

    // A reversal flips the low bit while staying on the same axis (up/down or left/right).
    assign reversal = (dir_req[1] == dir[1]) && (dir_req[0] != dir[0]);

    assign lfsr_fb  = lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5];

    // Unsigned 9-bit compare also catches coordinates that wrapped below zero.
    assign wall_hit = (snake_x0 >= GW) || (snake_y0 >= GH);
    assign self_hit = ((snake_x0 == snake_x1) && (snake_y0 == snake_y1)) ||
                      ((snake_x0 == snake_x2) && (snake_y0 == snake_y2)) ||
                      ((snake_x0 == snake_x3) && (snake_y0 == snake_y3)) ||
                      ((snake_x0 == snake_x4) && (snake_y0 == snake_y4));
    assign food_hit = (snake_x0 == food_x) && (snake_y0 == food_y);

    assign cand_x        = {3'b000, lfsr[5:0]};
    assign cand_y        = {4'b0000, lfsr[10:6]};
    assign cand_on_snake = ((cand_x == snake_x0) && (cand_y == snake_y0)) ||
                           ((cand_x == snake_x1) && (cand_y == snake_y1)) ||
                           ((cand_x == snake_x2) && (cand_y == snake_y2)) ||
                           ((cand_x == snake_x3) && (cand_y == snake_y3)) ||
                           ((cand_x == snake_x4) && (cand_y == snake_y4));
    assign cand_ok       = (cand_x < GW) && (cand_y < GH) && !cand_on_snake;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            dir       <= 2'd3;
            pend_dir  <= 2'd3;
            grow      <= 1'b0;
            food_x    <= FX0;
            food_y    <= FY0;
            score     <= 8'd0;
            game_over <= 1'b0;
            tick_pend <= 1'b0;
            lfsr      <= LFSR_SEED;
            tries     <= '0;
        end else begin
            lfsr <= {lfsr_fb, lfsr[15:1]};
            grow <= 1'b0;
            if (dir_valid && !reversal) begin
                pend_dir <= dir_req;
            end

            case (state)
                S_IDLE: begin
                    tick_pend <= 1'b0;
                    if (start) begin
                        state     <= S_RUN;
                        score     <= 8'd0;
                        game_over <= 1'b0;
                        food_x    <= FX0;
                        food_y    <= FY0;
                    end
                end

                S_RUN: begin
                    if (tick || tick_pend) begin
                        state     <= S_CHECK;
                        tick_pend <= 1'b0;
                        dir       <= pend_dir;
                    end
                end

                // Positions from snake_pos have settled one clock after the tick.
                S_CHECK: begin
                    if (tick) begin
                        tick_pend <= 1'b1;
                    end
                    if (wall_hit || self_hit) begin
                        state     <= S_OVER;
                        game_over <= 1'b1;
                    end else if (food_hit) begin
                        state <= S_PLACE;
                        grow  <= 1'b1;
                        tries <= '0;
                        if (score != 8'hFF) begin
                            score <= score + 8'd1;
                        end
                    end else begin
                        state <= S_RUN;
                    end
                end

                S_PLACE: begin
                    if (tick) begin
                        tick_pend <= 1'b1;
                    end
                    if (cand_ok) begin
                        food_x <= cand_x;
                        food_y <= cand_y;
                        state  <= S_RUN;
                    end else if (tries == TRY_LAST) begin
                        state <= S_RUN;
                    end else begin
                        tries <= tries + 1'b1;
                    end
                end

                S_OVER: begin
                    tick_pend <= 1'b0;
                    if (start) begin
                        state     <= S_RUN;
                        score     <= 8'd0;
                        game_over <= 1'b0;
                        food_x    <= FX0;
                        food_y    <= FY0;
                        dir       <= 2'd3;
                        pend_dir  <= 2'd3;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_ctrl.sv
// Directed testbench for snake_ctrl: drives snake coordinates and ticks by hand and
// compares outputs against hand-computed expectations.
module tb_snake_ctrl;

    localparam int PLACE_MAX = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       tick;
    logic [1:0] dir_req;
    logic       dir_valid;
    logic [8:0] sx [5];
    logic [8:0] sy [5];
    logic [1:0] dir;
    logic       grow;
    logic [8:0] food_x;
    logic [8:0] food_y;
    logic [7:0] score;
    logic       game_over;

    int   tests_run    = 0;
    int   tests_failed = 0;
    logic grow_hist [0:79];
    logic over_hist [0:79];
    logic over_pre;

    snake_ctrl #(
        .GRID_W(40), .GRID_H(30), .FOOD_X0(20), .FOOD_Y0(15),
        .LFSR_SEED(16'hACE1), .PLACE_MAX(PLACE_MAX)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .tick(tick),
        .dir_req(dir_req), .dir_valid(dir_valid),
        .snake_x0(sx[0]), .snake_x1(sx[1]), .snake_x2(sx[2]), .snake_x3(sx[3]), .snake_x4(sx[4]),
        .snake_y0(sy[0]), .snake_y1(sy[1]), .snake_y2(sy[2]), .snake_y3(sy[3]), .snake_y4(sy[4]),
        .dir(dir), .grow(grow), .food_x(food_x), .food_y(food_y),
        .score(score), .game_over(game_over)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Horizontal snake with the head at (hx,hy) and the body trailing to the left.
    task automatic setLine(input logic [8:0] hx, input logic [8:0] hy);
        for (int k = 0; k < 5; k++) begin
            sx[k] = hx - 9'(k);
            sy[k] = hy;
        end
    endtask

    // One tick pulse, then record grow/game_over for ncyc cycles; index 0 is two clocks after tick.
    task automatic applyStimulus(input int ncyc);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        over_pre = game_over;
        for (int k = 0; k < 80; k++) begin
            grow_hist[k] = 1'b0;
            over_hist[k] = 1'b0;
        end
        for (int k = 0; k < ncyc; k++) begin
            cycle();
            grow_hist[k] = grow;
            over_hist[k] = game_over;
        end
    endtask

    task automatic doStart();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic sendDir(input logic [1:0] d);
        dir_valid = 1'b1;
        dir_req   = d;
        cycle();
        dir_valid = 1'b0;
    endtask

    function automatic int growCount();
        int n = 0;
        for (int k = 0; k < 80; k++) n += int'(grow_hist[k]);
        return n;
    endfunction

    function automatic logic foodOnSnake();
        logic hit = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (sx[k] == food_x && sy[k] == food_y) hit = 1'b1;
        end
        return hit;
    endfunction

    initial begin
        rst_n     = 1'b0;
        start     = 1'b0;
        tick      = 1'b0;
        dir_req   = 2'd0;
        dir_valid = 1'b0;
        setLine(9'd5, 9'd5);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_dir", 32'(dir), 32'd3);
        checkOutput("rst_grow", 32'(grow), 32'd0);
        checkOutput("rst_food_x", 32'(food_x), 32'd20);
        checkOutput("rst_food_y", 32'(food_y), 32'd15);
        checkOutput("rst_score", 32'(score), 32'd0);
        checkOutput("rst_over", 32'(game_over), 32'd0);
        rst_n = 1'b1;
        cycle();

        // Test 1: ticks in IDLE are ignored, then a plain run to the right
        setLine(9'd40, 9'd5);
        applyStimulus(4);
        checkOutput("idle_tick_over", 32'(over_hist[0]), 32'd0);
        doStart();
        for (int i = 0; i < 4; i++) begin
            setLine(9'(6 + i), 9'd5);
            applyStimulus(4);
            checkOutput("run_dir", 32'(dir), 32'd3);
            checkOutput("run_grow", 32'(growCount()), 32'd0);
            checkOutput("run_score", 32'(score), 32'd0);
            checkOutput("run_over", 32'(game_over), 32'd0);
        end

        // Test 3: reversal ignored, last accepted request wins, simultaneous request/tick
        sendDir(2'd2);
        setLine(9'd10, 9'd5);
        applyStimulus(4);
        checkOutput("rev_ignored", 32'(dir), 32'd3);
        sendDir(2'd0);
        sendDir(2'd1);
        setLine(9'd11, 9'd5);
        applyStimulus(4);
        checkOutput("last_req_wins", 32'(dir), 32'd1);
        setLine(9'd11, 9'd6);
        dir_valid = 1'b1;
        dir_req   = 2'd2;
        tick      = 1'b1;
        cycle();
        dir_valid = 1'b0;
        tick      = 1'b0;
        checkOutput("sim_old_dir", 32'(dir), 32'd1);
        repeat (3) cycle();
        setLine(9'd10, 9'd6);
        applyStimulus(4);
        checkOutput("sim_new_dir", 32'(dir), 32'd2);

        // Test 2: eat the food at (20,15)
        setLine(9'd20, 9'd15);
        applyStimulus(PLACE_MAX + 2);
        checkOutput("eat_grow_at2", 32'(grow_hist[0]), 32'd1);
        checkOutput("eat_grow_once", 32'(growCount()), 32'd1);
        checkOutput("eat_score", 32'(score), 32'd1);
        checkOutput("eat_food_x_rng", 32'(food_x < 9'd40), 32'd1);
        checkOutput("eat_food_y_rng", 32'(food_y < 9'd30), 32'd1);
        checkOutput("eat_food_off", 32'(foodOnSnake()), 32'd0);
        checkOutput("eat_over", 32'(game_over), 32'd0);

        // Test 4: wall hits, ticks ignored in OVER, restart
        setLine(9'd40, 9'd15);
        applyStimulus(4);
        checkOutput("wall_over_pre", 32'(over_pre), 32'd0);
        checkOutput("wall_over_at2", 32'(over_hist[0]), 32'd1);
        checkOutput("wall_no_grow", 32'(growCount()), 32'd0);
        checkOutput("wall_score", 32'(score), 32'd1);
        setLine(9'd41, 9'd15);
        applyStimulus(4);
        checkOutput("over_stays", 32'(game_over), 32'd1);
        checkOutput("over_score", 32'(score), 32'd1);
        doStart();
        checkOutput("restart_over", 32'(game_over), 32'd0);
        checkOutput("restart_score", 32'(score), 32'd0);
        checkOutput("restart_dir", 32'(dir), 32'd3);
        checkOutput("restart_food_x", 32'(food_x), 32'd20);
        checkOutput("restart_food_y", 32'(food_y), 32'd15);
        setLine(9'd10, 9'd511);
        applyStimulus(4);
        checkOutput("wall_511", 32'(over_hist[0]), 32'd1);
        doStart();

        // Test 5: self collision, and self collision beating food
        setLine(9'd8, 9'd8);
        sx[3] = 9'd8;
        applyStimulus(4);
        checkOutput("self_seg3", 32'(over_hist[0]), 32'd1);
        doStart();
        setLine(9'd20, 9'd15);
        sx[2] = 9'd20;
        applyStimulus(4);
        checkOutput("self_food_over", 32'(game_over), 32'd1);
        checkOutput("self_food_grow", 32'(growCount()), 32'd0);
        checkOutput("self_food_score", 32'(score), 32'd0);
        doStart();

        // Test 6: asynchronous reset while placing food
        sendDir(2'd0);
        setLine(9'd20, 9'd15);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        cycle();
        checkOutput("pre_rst_grow", 32'(grow), 32'd1);
        checkOutput("pre_rst_score", 32'(score), 32'd1);
        checkOutput("pre_rst_dir", 32'(dir), 32'd0);
        rst_n = 1'b0;
        #1;
        checkOutput("arst_grow", 32'(grow), 32'd0);
        checkOutput("arst_score", 32'(score), 32'd0);
        checkOutput("arst_dir", 32'(dir), 32'd3);
        checkOutput("arst_food_x", 32'(food_x), 32'd20);
        checkOutput("arst_food_y", 32'(food_y), 32'd15);
        checkOutput("arst_over", 32'(game_over), 32'd0);
        cycle();
        rst_n = 1'b1;
        cycle();
        setLine(9'd40, 9'd15);
        applyStimulus(4);
        checkOutput("arst_idle_tick", 32'(over_hist[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
